// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg: shared MEM-stage state encodings and NOP constants
package riscv_pipe_pkg;
  typedef enum logic [1:0] {
    DMEM_IDLE      = 2'd0,
    DMEM_REQ       = 2'd1,
    DMEM_WAIT_RESP = 2'd2,
    DMEM_DONE      = 2'd3
  } dmem_state_t;
  localparam logic [4:0] NOP_RD_ADDR  = 5'd0;
  localparam logic       NOP_REGWRITE = 1'b0;
  localparam logic       NOP_MEMREAD  = 1'b0;
  localparam logic       NOP_MEMTOREG = 1'b0;
endpackage

// File: rtl/dmem_timeout_counter.sv
// dmem_timeout_counter: cycle counter flagging the last allowed cycle of a bus access
module dmem_timeout_counter #(
  parameter int MAX_COUNT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(MAX_COUNT + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= clear ? '0 : enable ? cnt + W'(1) : cnt;
  assign expired = enable && cnt == W'(MAX_COUNT - 1);
endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: MEM-stage load/store bus sequencer with pipeline freeze; DMEM_TIMEOUT_EN adds a timeout abort
import riscv_pipe_pkg::*;
module dmem_access_ctrl #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mem_memread,
  input  logic            mem_memwrite,
  input  logic [XLEN-1:0] mem_alu_result,
  input  logic [XLEN-1:0] mem_rs2_data,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            pipe_stall,
  output logic            mem_wb_bubble,
  output logic [XLEN-1:0] load_data,
  output logic            mem_misaligned,
  output logic            bus_error
);
  dmem_state_t state;
  logic we_q, access, aligned, accept, in_flight, abort;
  assign access         = mem_memread | mem_memwrite;
  assign aligned        = mem_alu_result[1:0] == 2'b00;
  // rst_n gating keeps the IDLE decode quiet while reset holds a live instruction
  assign accept         = rst_n && state == DMEM_IDLE && access && aligned;
  assign mem_misaligned = rst_n && state == DMEM_IDLE && access && !aligned;
  assign in_flight      = state == DMEM_REQ || state == DMEM_WAIT_RESP;
  assign pipe_stall     = accept | in_flight;
  assign mem_wb_bubble  = pipe_stall;
  assign dmem_req       = state == DMEM_REQ;
  assign dmem_we        = dmem_req & we_q;
`ifdef DMEM_TIMEOUT_EN
  logic bus_err_q;
  dmem_timeout_counter #(.MAX_COUNT(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (accept),
    .enable  (in_flight),
    .expired (abort)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) bus_err_q <= 1'b0;
    else bus_err_q <= abort;
  assign bus_error = bus_err_q;
`else
  assign abort     = 1'b0;
  assign bus_error = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= DMEM_IDLE;
      we_q       <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      load_data  <= '0;
    end else begin
      case (state)
        DMEM_IDLE: if (accept) begin
          state      <= DMEM_REQ;
          we_q       <= !mem_memread;
          dmem_addr  <= {mem_alu_result[XLEN-1:2], 2'b00};
          dmem_wdata <= mem_rs2_data;
        end
        DMEM_REQ: if (abort) begin
          state     <= DMEM_DONE;
          load_data <= '0;
        end else if (dmem_gnt) state <= we_q ? DMEM_DONE : DMEM_WAIT_RESP;
        DMEM_WAIT_RESP: if (abort) begin
          state     <= DMEM_DONE;
          load_data <= '0;
        end else if (dmem_rvalid) begin
          state     <= DMEM_DONE;
          load_data <= dmem_rdata;
        end
        default: state <= DMEM_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: directed-vector bench for the MEM-stage access controller
module tb_dmem_access_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_memread = 1'b0, mem_memwrite = 1'b0;
  logic [31:0] mem_alu_result = '0, mem_rs2_data = '0;
  logic        dmem_req, dmem_we, dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = '0, load_data;
  logic        pipe_stall, mem_wb_bubble, mem_misaligned, bus_error;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  dmem_access_ctrl #(.XLEN(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .mem_alu_result(mem_alu_result), .mem_rs2_data(mem_rs2_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .pipe_stall(pipe_stall), .mem_wb_bubble(mem_wb_bubble), .load_data(load_data),
    .mem_misaligned(mem_misaligned), .bus_error(bus_error)
  );
  task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic g, input logic rv, input logic [31:0] rdat);
    @(negedge clk);
    mem_memread = rd; mem_memwrite = wr; mem_alu_result = a; mem_rs2_data = wd;
    dmem_gnt = g; dmem_rvalid = rv; dmem_rdata = rdat;
    #1;
  endtask
  task automatic test_reset;
    @(negedge clk); #1;
    tests++; if ({dmem_req, dmem_we, pipe_stall, mem_wb_bubble, mem_misaligned, bus_error} !== 6'b0) begin
      fails++; $display("FAIL reset_ctrl: got %b want 000000", {dmem_req, dmem_we, pipe_stall, mem_wb_bubble, mem_misaligned, bus_error}); end
    tests++; if ({dmem_addr, dmem_wdata, load_data} !== 96'b0) begin
      fails++; $display("FAIL reset_data: addr=%h wdata=%h load=%h want all 0", dmem_addr, dmem_wdata, load_data); end
    @(negedge clk); rst_n = 1'b1;
  endtask
  task automatic test_store;
    int stalls = 0;
    for (int c = 0; c < 4; c++) begin
      drive(c <= 2, 1'b0, 32'h100, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0);
      mem_memwrite = (c <= 2); mem_memread = 1'b0; #0;
      stalls += int'(pipe_stall);
      tests++; if (dmem_req !== (c == 1) || dmem_we !== (c == 1)) begin
        fails++; $display("FAIL store_req c%0d: req=%b we=%b want %b", c, dmem_req, dmem_we, c == 1); end
      tests++; if (mem_wb_bubble !== pipe_stall || bus_error !== 1'b0) begin
        fails++; $display("FAIL store_bubble c%0d: bubble=%b stall=%b berr=%b", c, mem_wb_bubble, pipe_stall, bus_error); end
      if (c == 1) begin
        tests++; if (dmem_addr !== 32'h100 || dmem_wdata !== 32'hDEADBEEF) begin
          fails++; $display("FAIL store_bus: addr=%h wdata=%h want 00000100 deadbeef", dmem_addr, dmem_wdata); end
      end
    end
    tests++; if (stalls != 2) begin fails++; $display("FAIL store_stall_len: got %0d want 2", stalls); end
  endtask
  task automatic test_load;
    for (int c = 0; c < 9; c++) begin
      drive(c <= 7, 1'b0, 32'h200, 32'h0, c == 4, c == 4 || c == 6, c == 4 ? 32'hBAD0BAD0 : 32'h12345678);
      tests++; if (pipe_stall !== (c <= 6) || dmem_req !== (c >= 1 && c <= 4) || dmem_we !== 1'b0) begin
        fails++; $display("FAIL load_seq c%0d: stall=%b req=%b we=%b want %b %b 0", c, pipe_stall, dmem_req, dmem_we, c <= 6, c >= 1 && c <= 4); end
      if (c == 2) begin
        tests++; if (dmem_addr !== 32'h200) begin fails++; $display("FAIL load_addr: got %h want 00000200", dmem_addr); end
      end
      if (c == 7) begin
        tests++; if (load_data !== 32'h12345678) begin fails++; $display("FAIL load_data: got %h want 12345678", load_data); end
      end
    end
  endtask
  task automatic test_misaligned;
    for (int c = 0; c < 3; c++) begin
      drive(c == 0, 1'b0, 32'h203, 32'h0, 1'b1, 1'b0, 32'h0);
      tests++; if (mem_misaligned !== (c == 0) || dmem_req !== 1'b0 || pipe_stall !== 1'b0) begin
        fails++; $display("FAIL misaligned c%0d: mis=%b req=%b stall=%b want %b 0 0", c, mem_misaligned, dmem_req, pipe_stall, c == 0); end
    end
  endtask
  task automatic test_back_to_back;
    logic [7:0] exp_stall = 8'b0011_1011;
    logic [7:0] exp_req   = 8'b0001_0010;
    int reqs = 0;
    for (int c = 0; c < 8; c++) begin
      drive(c >= 3 && c <= 6, c <= 2, c <= 2 ? 32'h300 : 32'h304, 32'hA5A5A5A5, 1'b1, c == 5, 32'hCAFEF00D);
      reqs += int'(dmem_req);
      tests++; if (pipe_stall !== exp_stall[c] || dmem_req !== exp_req[c]) begin
        fails++; $display("FAIL b2b_seq c%0d: stall=%b req=%b want %b %b", c, pipe_stall, dmem_req, exp_stall[c], exp_req[c]); end
      if (c == 1 || c == 4) begin
        tests++; if (dmem_we !== (c == 1) || dmem_addr !== (c == 1 ? 32'h300 : 32'h304)) begin
          fails++; $display("FAIL b2b_bus c%0d: we=%b addr=%h", c, dmem_we, dmem_addr); end
      end
      if (c == 6) begin
        tests++; if (load_data !== 32'hCAFEF00D) begin fails++; $display("FAIL b2b_load: got %h want cafef00d", load_data); end
      end
    end
    tests++; if (reqs != 2) begin fails++; $display("FAIL b2b_req_count: got %0d want 2", reqs); end
  endtask
  task automatic test_timeout;
`ifdef DMEM_TIMEOUT_EN
    for (int c = 0; c < 11; c++) begin
      drive(c <= 9, 1'b0, 32'h500, 32'h0, 1'b0, 1'b0, 32'h0);
      tests++; if (pipe_stall !== (c <= 8) || dmem_req !== (c >= 1 && c <= 8) || bus_error !== (c == 9)) begin
        fails++; $display("FAIL timeout_seq c%0d: stall=%b req=%b berr=%b", c, pipe_stall, dmem_req, bus_error); end
      if (c == 9) begin
        tests++; if (load_data !== 32'h0) begin fails++; $display("FAIL timeout_load: got %h want 0", load_data); end
      end
    end
`endif
  endtask
  task automatic test_reset_in_wait;
    for (int c = 0; c < 3; c++) drive(1'b1, 1'b0, 32'h400, 32'h0, c == 1, 1'b0, 32'h0);
    tests++; if (pipe_stall !== 1'b1 || dmem_req !== 1'b0) begin
      fails++; $display("FAIL rstw_pre: stall=%b req=%b want 1 0", pipe_stall, dmem_req); end
    #1 rst_n = 1'b0; #1;
    tests++; if (pipe_stall !== 1'b0 || dmem_req !== 1'b0 || load_data !== 32'h0) begin
      fails++; $display("FAIL rstw_async: stall=%b req=%b load=%h want 0 0 0", pipe_stall, dmem_req, load_data); end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h55555555);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    tests++; if (load_data !== 32'h0 || pipe_stall !== 1'b0 || dmem_req !== 1'b0) begin
      fails++; $display("FAIL rstw_stale: load=%h stall=%b req=%b want 0 0 0", load_data, pipe_stall, dmem_req); end
  endtask
  initial begin
    test_reset;
    test_store;
    test_load;
    test_misaligned;
    test_back_to_back;
    test_timeout;
    test_reset_in_wait;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
